ic_fetch_unit: RTL and testbench

Instruction fetch sequencer between the decode stage and the instruction cache's fetch port. Owns the fetch PC and issues one halfword-aligned 32-bit fetch at a time. It classifies each returned word as a compressed (16-bit) or full (32-bit) instruction, advances the PC by the instruction length, and buffers decoded-ready instructions in a small queue. Handles redirects (branch/trap) by flushing the queue and discarding any in-flight cache response.

---
 rtl/ic_pkg.sv | 30 +++
 rtl/ic_fetch_fifo.sv | 73 +++++++
 rtl/ic_fetch_unit.sv | 118 +++++++++++
 tb/tb_ic_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared types and helpers for the instruction-fetch path: PC type, queue entry,
// fetch sequencer states and the RISC-V length decode.
package ic_pkg;

    typedef logic [26:1] ic_pc_t;

    typedef struct packed {
        ic_pc_t      pc;
        logic [31:0] instr;
        logic        compressed;
    } ic_fq_entry_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } ic_fetch_state_t;

    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

    // Anything whose two low bits are not 2'b11 is a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] lsb);
        return (lsb != 2'b11);
    endfunction

    function automatic ic_pc_t pc_step(input ic_pc_t pc, input logic compressed);
        return compressed ? (pc + 26'd1) : (pc + 26'd2);
    endfunction

endpackage

// File: rtl/ic_fetch_fifo.sv
// Synchronous FIFO of fetched instructions; flush wins over push and pop,
// and the head reads as all-zero whenever the queue is empty.
module ic_fetch_fifo
    import ic_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_p,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  ic_fq_entry_t             push_data,
    output ic_fq_entry_t             head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    ic_fq_entry_t   mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign do_push_s  = push && (count_r < CW'(DEPTH));
    assign do_pop_s   = pop && (count_r != {CW{1'b0}});
    assign head_valid = (count_r != {CW{1'b0}});
    assign count      = count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        head = '0;
        if (head_valid) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = '0;
        end
    end

endmodule

// File: rtl/ic_fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC, issues one cache fetch at a
// time, length-decodes the returned word and queues instructions for decode.
module ic_fetch_unit
    import ic_pkg::*;
#(
    parameter ic_pc_t      RESET_PC = 26'h0000000,
    parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_p,
    input  logic         redirect_en,
    input  logic [26:1]  redirect_pc,
    output logic [26:1]  fetch_addr,
    output logic         fetch_en,
    input  logic         fetch_valid,
    input  logic [31:0]  fetch_data,
    output logic         dec_valid,
    input  logic         dec_ready,
    output logic [31:0]  dec_instr,
    output logic [26:1]  dec_pc,
    output logic         dec_compressed
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    ic_fetch_state_t state_r;
    ic_fetch_state_t state_nxt_s;
    ic_pc_t          pc_r;
    logic [CW-1:0]   count_s;
    logic            space_s;
    logic            fetch_en_s;
    logic            push_s;
    logic            compressed_s;
    ic_fq_entry_t    push_entry_s;
    ic_fq_entry_t    head_s;

    assign space_s      = (count_s < CW'(FQ_DEPTH));
    assign compressed_s = is_compressed(fetch_data[1:0]);

    assign push_entry_s.pc         = pc_r;
    assign push_entry_s.instr      = compressed_s ? {16'h0000, fetch_data[15:0]} : fetch_data;
    assign push_entry_s.compressed = compressed_s;

    // Next-state, fetch request and push decision; a redirect always suppresses the push.
    always_comb begin
        state_nxt_s = state_r;
        fetch_en_s  = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            REQ: begin
                fetch_en_s = space_s && !redirect_en;
                if (fetch_en_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (fetch_valid) begin
                    push_s      = !redirect_en;
                    state_nxt_s = REQ;
                end else if (redirect_en) begin
                    state_nxt_s = KILL;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            KILL: begin
                if (fetch_valid) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = KILL;
                end
            end
            default: begin
                state_nxt_s = REQ;
            end
        endcase
    end

    // Sequencer state and fetch PC.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_r <= REQ;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            if (redirect_en) begin
                pc_r <= redirect_pc;
            end else if (push_s) begin
                pc_r <= pc_step(pc_r, compressed_s);
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    ic_fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_p      (rst_p),
        .push       (push_s),
        .pop        (dec_ready),
        .flush      (redirect_en),
        .push_data  (push_entry_s),
        .head       (head_s),
        .head_valid (dec_valid),
        .count      (count_s)
    );

    assign fetch_addr     = pc_r;
    assign fetch_en       = fetch_en_s;
    assign dec_instr      = head_s.instr;
    assign dec_pc         = head_s.pc;
    assign dec_compressed = head_s.compressed;

endmodule

// File: tb/tb_ic_fetch_unit.sv
// Self-checking bench for ic_fetch_unit: a behavioural cache with random latency
// plus a queue-based reference model, directed scenarios then random traffic.
module tb_ic_fetch_unit;
    import ic_pkg::*;

    localparam int     DEPTH  = 4;
    localparam ic_pc_t RST_PC = 26'h0000000;

    logic        clk;
    logic        rst_p;
    logic        redirect_en;
    logic [26:1] redirect_pc;
    logic [26:1] fetch_addr;
    logic        fetch_en;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [26:1] dec_pc;
    logic        dec_compressed;

    ic_fetch_unit #(
        .RESET_PC (RST_PC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_p          (rst_p),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .fetch_addr     (fetch_addr),
        .fetch_en       (fetch_en),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_compressed (dec_compressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: expected instruction queue, PC and request bookkeeping.
    ic_fq_entry_t mq[$];
    ic_pc_t       mpc;
    bit           outstanding;
    bit           discard;

    // Behavioural cache.
    bit           pend_valid;
    int           pend_cnt;
    logic [31:0]  pend_data;
    int           lat_lo;
    int           lat_hi;
    bit           force_en;
    logic [31:0]  force_val;
    int           en_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 1) == 0) begin
            w[1:0] = 2'b11;
        end else begin
            w[1:0] = 2'($urandom_range(0, 2));
        end
        return w;
    endfunction

    task automatic cache_tick();
        if (fetch_valid) begin
            pend_valid = 1'b0;
        end else if (pend_valid) begin
            pend_cnt--;
        end
    endtask

    task automatic cycle(input bit redir, input ic_pc_t rpc, input bit rdy);
        bit           exp_en;
        bit           comp;
        logic [31:0]  d;
        ic_fq_entry_t e;
        @(negedge clk);
        rst_p       = 1'b0;
        fetch_valid = pend_valid && (pend_cnt == 0);
        fetch_data  = fetch_valid ? pend_data : $urandom;
        redirect_en = redir;
        redirect_pc = rpc;
        dec_ready   = rdy;
        #1;
        exp_en = !outstanding && (mq.size() < DEPTH) && !redir;
        chk("fetch_en", 32'(fetch_en), 32'(exp_en));
        chk("fetch_addr", 32'(fetch_addr), 32'(mpc));
        chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("dec_pc", 32'(dec_pc), 32'(mq[0].pc));
            chk("dec_instr", dec_instr, mq[0].instr);
            chk("dec_compressed", 32'(dec_compressed), 32'(mq[0].compressed));
        end
        if (fetch_en) en_seen++;
        if (redir) begin
            mq.delete();
            mpc = rpc;
            if (outstanding) begin
                if (fetch_valid) begin
                    outstanding = 1'b0;
                    discard     = 1'b0;
                end else begin
                    discard = 1'b1;
                end
            end
        end else begin
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (fetch_valid && outstanding) begin
                if (!discard) begin
                    d      = fetch_data;
                    comp   = (d[1:0] != 2'b11);
                    e.pc   = mpc;
                    e.instr = comp ? (d & 32'h0000FFFF) : d;
                    e.compressed = comp;
                    mq.push_back(e);
                    mpc = mpc + (comp ? 26'd1 : 26'd2);
                end
                outstanding = 1'b0;
                discard     = 1'b0;
            end
            if (exp_en) outstanding = 1'b1;
        end
        cache_tick();
        if (exp_en) begin
            pend_valid = 1'b1;
            pend_cnt   = int'($urandom_range(lat_lo, lat_hi)) - 1;
            pend_data  = force_en ? force_val : rand_word();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_p       = 1'b1;
        redirect_en = 1'b0;
        dec_ready   = 1'b0;
        fetch_valid = pend_valid && (pend_cnt == 0);
        fetch_data  = fetch_valid ? pend_data : $urandom;
        mq.delete();
        mpc         = RST_PC;
        outstanding = 1'b0;
        discard     = 1'b0;
        cache_tick();
        @(posedge clk);
        #1;
        rst_p       = 1'b0;
        fetch_valid = 1'b0;
        chk("rst_fetch_en", 32'(fetch_en), 32'd1);
        chk("rst_fetch_addr", 32'(fetch_addr), 32'(RST_PC));
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", 32'(dec_pc), 32'd0);
        chk("rst_dec_compressed", 32'(dec_compressed), 32'd0);
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ic_pc_t rpc;
        int     guard;
        bit     redir;
        n_checks = 0; n_errors = 0;
        rst_p = 1'b1; redirect_en = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        fetch_valid = 1'b0; fetch_data = 32'd0;
        pend_valid = 1'b0; pend_cnt = 0; pend_data = 32'd0;
        lat_lo = 1; lat_hi = 1; force_en = 1'b0; force_val = 32'd0; en_seen = 0;
        mpc = RST_PC; outstanding = 1'b0; discard = 1'b0;

        do_reset();

        // Compressed word at the reset PC.
        force_en = 1'b1; force_val = 32'h0000_4501;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        force_en = 1'b0;
        peek();
        chk("c16_compressed", 32'(dec_compressed), 32'd1);
        chk("c16_instr", dec_instr, 32'h0000_4501);
        chk("c16_pc", 32'(dec_pc), 32'd0);
        chk("c16_next_addr", 32'(fetch_addr), 32'd1);

        // Full 32-bit word at PC 5.
        cycle(1'b1, 26'd5, 1'b1);
        force_en = 1'b1; force_val = 32'h0010_0093;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        force_en = 1'b0;
        peek();
        chk("c32_compressed", 32'(dec_compressed), 32'd0);
        chk("c32_instr", dec_instr, 32'h0010_0093);
        chk("c32_pc", 32'(dec_pc), 32'd5);
        chk("c32_next_addr", 32'(fetch_addr), 32'd7);

        // Fill the queue with decode stalled, then free one slot.
        cycle(1'b1, 26'h20, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
        en_seen = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0);
        chk("full_no_fetch", 32'(en_seen), 32'd0);
        en_seen = 0;
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0);
        chk("one_refill", 32'(en_seen), 32'd1);

        // Redirect while waiting; response three cycles later is discarded.
        cycle(1'b1, 26'h40, 1'b1);
        lat_lo = 4; lat_hi = 4;
        cycle(1'b0, '0, 1'b0);
        en_seen = 0;
        cycle(1'b1, 26'h100, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        chk("kill_no_fetch", 32'(en_seen), 32'd0);
        peek();
        chk("kill_dec_valid", 32'(dec_valid), 32'd0);
        chk("kill_addr", 32'(fetch_addr), 32'h100);
        chk("kill_refetch", 32'(fetch_en), 32'd1);

        // Redirect coincident with response and pop.
        lat_lo = 1; lat_hi = 1;
        cycle(1'b1, 26'h200, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 26'h300, 1'b1);
        peek();
        chk("coinc_dec_valid", 32'(dec_valid), 32'd0);
        chk("coinc_addr", 32'(fetch_addr), 32'h300);
        cycle(1'b0, '0, 1'b0);

        // PC wrap on a 32-bit instruction at the top of the space.
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 26'h3FFFFFF, 1'b1);
        force_en = 1'b1; force_val = 32'h0000_0013;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        force_en = 1'b0;
        peek();
        chk("wrap_addr", 32'(fetch_addr), 32'd1);
        chk("wrap_dec_pc", 32'(dec_pc), 32'h3FFFFFF);

        // Reset while waiting; the late response must be ignored.
        lat_lo = 3; lat_hi = 3;
        cycle(1'b0, '0, 1'b0);
        do_reset();
        guard = 0;
        while (pend_valid && guard < 10) begin
            cycle(1'b1, RST_PC, 1'b0);
            guard++;
        end
        chk("late_rsp_drained", 32'(pend_valid), 32'd0);
        peek();
        chk("late_dec_valid", 32'(dec_valid), 32'd0);
        chk("late_addr", 32'(fetch_addr), 32'(RST_PC));

        // Random traffic.
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            redir = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) begin
                rpc = 26'h3FFFFFE + ic_pc_t'($urandom_range(0, 1));
            end else begin
                rpc = ic_pc_t'($urandom);
            end
            cycle(redir, rpc, ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
